// File: rtl/sram_word_bridge.sv
// sram_word_bridge
// Multi-cycle bridge between the MEM stage and an asynchronous SRAM. Each
// DATA_W word is moved as BEATS = DATA_W/SRAM_DW narrow beats, low slice first,
// each beat stretched by WAIT extra cycles. o_sram_not_ready freezes the
// pipeline until the DONE cycle of the word transfer.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_rd_en, i_wr_en       level requests, held until o_sram_not_ready falls
//   i_word_idx             word index (SRAM address without beat bits)
//   i_wr_data              write word, latched when the request is accepted
//   o_rd_data              assembled read word, updated only when a read ends
//   o_sram_not_ready       stall to the hazard unit (combinational)
//   o_sram_addr            SRAM address {word_idx, beat}
//   o_sram_we_n/oe_n       active-low SRAM strobes
//   io_sram_dq             SRAM data bus, driven only while writing
module sram_word_bridge #(
  parameter  int DATA_W  = 32,
  parameter  int SRAM_DW = 16,
  parameter  int SRAM_AW = 18,
  parameter  int WAIT    = 1,
  localparam int BEATS   = DATA_W / SRAM_DW,
  localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 0,
  localparam int IDX_W   = SRAM_AW - BW
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rd_en,
  input  logic               i_wr_en,
  input  logic [IDX_W-1:0]   i_word_idx,
  input  logic [DATA_W-1:0]  i_wr_data,
  output logic [DATA_W-1:0]  o_rd_data,
  output logic               o_sram_not_ready,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic               o_sram_we_n,
  output logic               o_sram_oe_n,
  inout  tri   [SRAM_DW-1:0] io_sram_dq
);

  localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WCW = $clog2(WAIT + 2) + 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [WCW-1:0] W_LAST    = WCW'(WAIT);      // last strobe cycle
  localparam logic [WCW-1:0] W_RECOV   = WCW'(WAIT + 1);  // write recovery cycle

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t             r_state;
  logic [BCW-1:0]     r_beat;
  logic [WCW-1:0]     r_wait;
  logic [DATA_W-1:0]  r_rsh;    // read assembly register
  logic [DATA_W-1:0]  r_wsh;    // write word, shifted down one slice per beat
  logic               r_dq_oe;
  logic [DATA_W-1:0]  w_asm;

  // Assembly register with the current beat's slice taken from the bus; used
  // both for the per-beat capture and for the final word on the last beat.
  always_comb begin
    w_asm = r_rsh;
    w_asm[int'(r_beat)*SRAM_DW +: SRAM_DW] = io_sram_dq;
  end

  assign o_sram_not_ready = (i_rd_en | i_wr_en) & (r_state != S_DONE);
  assign io_sram_dq       = r_dq_oe ? r_wsh[SRAM_DW-1:0] : {SRAM_DW{1'bz}};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_wait      <= '0;
      r_rsh       <= '0;
      r_wsh       <= '0;
      r_dq_oe     <= 1'b0;
      o_rd_data   <= '0;
      o_sram_addr <= '0;
      o_sram_we_n <= 1'b1;
      o_sram_oe_n <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_beat <= '0;
          r_wait <= '0;
          // Beat bits sit in the low address bits, so later beats just add 1.
          if (i_wr_en) begin
            r_state     <= S_WRITE;
            r_wsh       <= i_wr_data;
            r_dq_oe     <= 1'b1;
            o_sram_we_n <= 1'b0;
            o_sram_addr <= SRAM_AW'(i_word_idx) << BW;
          end else if (i_rd_en) begin
            r_state     <= S_READ;
            o_sram_oe_n <= 1'b0;
            o_sram_addr <= SRAM_AW'(i_word_idx) << BW;
          end
        end
        S_READ: begin
          if (r_wait == W_LAST) begin
            r_rsh  <= w_asm;
            r_wait <= '0;
            if (r_beat == LAST_BEAT) begin
              r_state     <= S_DONE;
              o_sram_oe_n <= 1'b1;
              o_rd_data   <= w_asm;
            end else begin
              r_beat      <= r_beat + 1'b1;
              o_sram_addr <= o_sram_addr + 1'b1;
            end
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_WRITE: begin
          if (r_wait == W_RECOV) begin
            r_wait <= '0;
            if (r_beat == LAST_BEAT) begin
              r_state <= S_DONE;
              r_dq_oe <= 1'b0;
            end else begin
              r_beat      <= r_beat + 1'b1;
              o_sram_addr <= o_sram_addr + 1'b1;
              r_wsh       <= r_wsh >> SRAM_DW;
              o_sram_we_n <= 1'b0;
            end
          end else begin
            r_wait <= r_wait + 1'b1;
            // Release we_n one cycle before the beat ends so addr/dq stay
            // valid across the rising edge of the strobe.
            if (r_wait == W_LAST) o_sram_we_n <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_word_bridge.sv
// Bench for sram_word_bridge: a default instance (32/16, WAIT=1) and a
// single-beat variant (16/16, WAIT=0), each with an SRAM model. Expected bus
// activity is derived per cycle from beat/phase arithmetic; expected read
// words come from a word-level reference array.
module tb_sram_word_bridge;
  localparam int SW = 16, AW = 18;
  localparam int A_WT = 1, A_IW = 17;
  localparam int B_WT = 0, B_IW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, mem_init;
  logic a_rd, a_wr, b_rd, b_wr;
  logic [A_IW-1:0] a_idx;
  logic [B_IW-1:0] b_idx;
  logic [31:0] a_wd, a_rdd;
  logic [15:0] b_wd, b_rdd;
  logic a_nr, a_we, a_oe, b_nr, b_we, b_oe;
  logic [AW-1:0] a_addr, b_addr;
  tri   [SW-1:0] a_dq, b_dq;
  pullup (a_dq);
  pullup (b_dq);

  sram_word_bridge #(.DATA_W(32), .SRAM_DW(SW), .SRAM_AW(AW), .WAIT(A_WT)) u_a (
    .i_clk(clk), .i_rst(rst), .i_rd_en(a_rd), .i_wr_en(a_wr), .i_word_idx(a_idx),
    .i_wr_data(a_wd), .o_rd_data(a_rdd), .o_sram_not_ready(a_nr), .o_sram_addr(a_addr),
    .o_sram_we_n(a_we), .o_sram_oe_n(a_oe), .io_sram_dq(a_dq));

  sram_word_bridge #(.DATA_W(16), .SRAM_DW(SW), .SRAM_AW(AW), .WAIT(B_WT)) u_b (
    .i_clk(clk), .i_rst(rst), .i_rd_en(b_rd), .i_wr_en(b_wr), .i_word_idx(b_idx),
    .i_wr_data(b_wd), .o_rd_data(b_rdd), .o_sram_not_ready(b_nr), .o_sram_addr(b_addr),
    .o_sram_we_n(b_we), .o_sram_oe_n(b_oe), .io_sram_dq(b_dq));

  function automatic logic [15:0] fa(int a);
    return 16'(a * 40503) ^ 16'h1234;
  endfunction
  function automatic logic [15:0] fb(int a);
    return 16'(a * 7919) ^ 16'hC3A5;
  endfunction

  // SRAM models: read data driven while oe_n low and we_n high, write on clock.
  logic [15:0] mema [0:1023];
  logic [15:0] memb [0:1023];
  assign a_dq = (!a_oe && a_we) ? mema[a_addr[9:0]] : {SW{1'bz}};
  assign b_dq = (!b_oe && b_we) ? memb[b_addr[9:0]] : {SW{1'bz}};
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) begin
        mema[i] <= fa(i);
        memb[i] <= fb(i);
      end
    end else begin
      if (!a_we) mema[a_addr[9:0]] <= a_dq;
      if (!b_we) memb[b_addr[9:0]] <= b_dq;
    end
  end

  // Word-level reference
  logic [31:0] refa [0:511];
  logic [15:0] refb [0:1023];
  logic [31:0] last_rd [2];

  int checks = 0, errors = 0;
  bit sel;

  wire        s_nr   = sel ? b_nr : a_nr;
  wire        s_we   = sel ? b_we : a_we;
  wire        s_oe   = sel ? b_oe : a_oe;
  wire [AW-1:0] s_addr = sel ? b_addr : a_addr;
  wire [15:0] s_dq   = sel ? b_dq : a_dq;
  wire [31:0] s_rdd  = sel ? {16'd0, b_rdd} : a_rdd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One full request on the selected instance, checked cycle by cycle.
  task automatic xact(input bit wr, input bit rd, input int idx, input logic [31:0] din);
    int bt, wt, len, per, b, p;
    logic [31:0] d, word;
    logic [AW-1:0] ea;
    logic ewe, eoe;
    d    = sel ? {16'd0, din[15:0]} : din;
    bt   = sel ? 1 : 2;
    wt   = sel ? B_WT : A_WT;
    per  = wr ? wt + 2 : wt + 1;
    len  = bt * per;
    word = wr ? d : (sel ? {16'd0, refb[idx]} : refa[idx]);
    @(negedge clk);
    chk("idle_nr", 64'(s_nr), 64'd0);
    chk("idle_dq", 64'(s_dq), 64'hffff);
    if (sel) begin b_wr = wr; b_rd = rd; b_idx = B_IW'(idx); b_wd = d[15:0]; end
    else     begin a_wr = wr; a_rd = rd; a_idx = A_IW'(idx); a_wd = d; end
    #1 chk("req_nr", 64'(s_nr), 64'd1);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      b   = (c - 1) / per;
      p   = (c - 1) % per;
      ea  = AW'(idx * bt + b);
      ewe = wr ? (p > wt) : 1'b1;
      eoe = wr;
      if (wr) begin
        chk("wr_cyc", 64'({s_nr, s_we, s_oe, s_addr}), 64'({1'b1, ewe, eoe, ea}));
        chk("wr_dq", 64'(s_dq), 64'(word[b*16 +: 16]));
      end else begin
        chk("rd_cyc", 64'({s_nr, s_we, s_oe, s_addr}), 64'({1'b1, ewe, eoe, ea}));
      end
    end
    @(negedge clk);
    if (wr) begin
      if (sel) refb[idx] = d[15:0]; else refa[idx] = d;
    end else begin
      last_rd[sel] = word;
    end
    chk("done_nr", 64'(s_nr), 64'd0);
    chk("done_rd", 64'(s_rdd), 64'(last_rd[sel]));
    chk("done_str", 64'({s_we, s_oe}), 64'd3);
    if (sel) begin b_wr = 1'b0; b_rd = 1'b0; end
    else     begin a_wr = 1'b0; a_rd = 1'b0; end
  endtask

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    a_rd = 1'b1; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
    a_idx = '0; b_idx = '0; a_wd = '0; b_wd = '0;
    for (int i = 0; i < 512; i++) refa[i] = {fa(2*i + 1), fa(2*i)};
    for (int i = 0; i < 1024; i++) refb[i] = fb(i);
    last_rd[0] = '0; last_rd[1] = '0;
    sel = 1'b0;

    // Reset: stall follows the request even while held in reset.
    @(negedge clk);
    mem_init = 1'b0;
    chk("rst_nr_req", 64'(a_nr), 64'd1);
    a_rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_a", 64'({a_nr, a_we, a_oe, a_addr, a_rdd}), 64'({1'b0, 1'b1, 1'b1, 18'd0, 32'd0}));
    chk("rst_a_dq", 64'(a_dq), 64'hffff);
    chk("rst_b", 64'({b_nr, b_we, b_oe, b_addr, b_rdd}), 64'({1'b0, 1'b1, 1'b1, 18'd0, 16'd0}));
    chk("rst_b_dq", 64'(b_dq), 64'hffff);

    // Directed default-instance cases
    xact(1'b1, 1'b0, 'h12, 32'hDEADBEEF);
    xact(1'b0, 1'b1, 'h12, 32'h0);
    xact(1'b1, 1'b1, 'h13, 32'h13572468);   // write wins, rd_data unchanged
    xact(1'b0, 1'b1, 'h13, 32'h0);
    xact(1'b0, 1'b1, 'h1ff, 32'h0);         // unwritten location

    // Randomized traffic on the default instance
    for (int n = 0; n < 24; n++) begin
      int op;
      op = int'($urandom_range(0, 2));
      xact(op != 0, op != 1, int'($urandom_range(0, 511)), $urandom);
    end

    // Reset during the third READ cycle discards the partial read.
    @(negedge clk);
    a_rd = 1'b1; a_idx = A_IW'(5);
    repeat (3) @(negedge clk);
    chk("rst_mid_oe", 64'(a_oe), 64'd0);
    rst = 1'b1; a_rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = '0;
    chk("rst_mid", 64'({a_nr, a_we, a_oe, a_addr, a_rdd}), 64'({1'b0, 1'b1, 1'b1, 18'd0, 32'd0}));
    xact(1'b0, 1'b1, 5, 32'h0);

    // Single-beat variant
    sel = 1'b1;
    xact(1'b1, 1'b0, 'h2a5, 32'h0000BEEF);
    xact(1'b0, 1'b1, 'h2a5, 32'h0);
    xact(1'b1, 1'b1, 'h3ff, 32'h00001234);
    for (int n = 0; n < 16; n++) begin
      int op;
      op = int'($urandom_range(0, 2));
      xact(op != 0, op != 1, int'($urandom_range(0, 1023)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_word_bridge.md
# sram_word_bridge

Parametrised, multi-cycle bridge between the MEM stage and an external asynchronous SRAM. It splits each `DATA_W` word access into `BEATS = DATA_W/SRAM_DW` narrow SRAM accesses, each with programmable wait states. It reassembles read data and holds `sram_not_ready` high so the hazard unit freezes the pipeline until the word transfer finishes. It generalises the fixed 32-bit/16-bit, fixed-latency memory path to any integer width ratio and wait count.

## Interface
Parameters:
- `DATA_W`, 32, CPU word width; must be an integer multiple of `SRAM_DW`.
- `SRAM_DW`, 16, SRAM data bus width.
- `SRAM_AW`, 18, SRAM address width.
- `WAIT`, 1, extra cycles per SRAM beat (≥0); each beat is active for `WAIT+1` cycles.
- Derived: `BEATS = DATA_W/SRAM_DW`; `BW = clog2(BEATS)` (0 when `BEATS`=1); `IDX_W = SRAM_AW-BW`.

Ports:
- `clk`, in, 1, sole clock; all state updates on the rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `rd_en`, in, 1, MEM-stage read request, level; held until `sram_not_ready` falls.
- `wr_en`, in, 1, MEM-stage write request, level; same rule.
- `word_idx`, in, `IDX_W`, word index.
- `wr_data`, in, `DATA_W`, write word; sampled when the request is accepted.
- `rd_data`, out, `DATA_W`, assembled read word.
- `sram_not_ready`, out, 1, stall to the hazard unit.
- `sram_addr`, out, `SRAM_AW`, SRAM address.
- `sram_we_n`, out, 1, active-low write enable.
- `sram_oe_n`, out, 1, active-low output enable.
- `sram_dq`, inout, `SRAM_DW`, SRAM data; high-Z unless writing.

## Operation
- Beat k (0…BEATS-1) addresses `{word_idx, k[BW-1:0]}`. It carries `word[k*SRAM_DW +: SRAM_DW]`, so beat 0 holds the low half.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE: `wr_en` → WRITE; else `rd_en` → READ. Write wins when both are high. On entry, latch `word_idx` and `wr_data`, and clear the beat and wait counters.
  - READ: `sram_oe_n`=0, `sram_we_n`=1. Each beat lasts `WAIT+1` cycles. On the beat's last cycle, `sram_dq` is captured into the slice for beat k of the read shift/assembly register. After the last beat → DONE.
  - WRITE: each beat lasts `WAIT+2` cycles.
    - `sram_we_n`=0 for the first `WAIT+1` cycles, then `sram_we_n`=1 for one recovery cycle.
    - `sram_addr` and `sram_dq` are held stable for the whole beat.
    - After the last beat → DONE.
  - DONE: one cycle. `sram_not_ready`=0. After a read, `rd_data` holds the complete word. Next state is IDLE unconditionally, so the pipeline advances on this edge.
- `sram_not_ready` = (`rd_en`|`wr_en`) & (state≠DONE). It is combinational, so it rises in the same cycle a request appears in IDLE.
- `rd_data` updates only when a read finishes. It holds its value across writes and idle cycles.
- `sram_addr` holds its last value in IDLE and DONE.
- `sram_dq` is driven only in WRITE and is high-Z in every other state.
- A request that drops mid-transfer (illegal per the handshake) does not abort the transfer. The FSM completes it and `sram_not_ready` goes low.

## Timing
- Reset values:
  - state IDLE
  - `rd_data`=0
  - `sram_addr`=0
  - `sram_we_n`=1
  - `sram_oe_n`=1
  - `sram_dq` high-Z
  - counters 0
  - `sram_not_ready` follows the requests (high if a request is present).
- Reset in any state returns to IDLE on the next edge. A partial read is discarded, and `rd_data` is cleared to 0. A partial write may leave some SRAM beats written.
- Read: request in cycle 0, READ in cycles 1…`BEATS*(WAIT+1)`, DONE in the next cycle. Stall length is `BEATS*(WAIT+1)+1` cycles; defaults give a 5-cycle stall with DONE in cycle 5.
- Write: stall length is `BEATS*(WAIT+2)+1` cycles; defaults give 7.
- Back-to-back requests: a new request seen in IDLE, one cycle after DONE, starts immediately. There is no turnaround gap beyond that IDLE cycle.
- `BEATS`=1: BW=0 and `sram_addr`=`word_idx`, with the same FSM.

## Test plan
- Reset: hold `rst` for 2 cycles with `rd_en`=0 and `wr_en`=0. Required: `sram_we_n`=1, `sram_oe_n`=1, `sram_dq`=Z, `rd_data`=0, `sram_not_ready`=0.
- Defaults, write of idx 0x00012 with data 0xDEADBEEF. Required:
  - `sram_addr`=0x00024 with dq=0xBEEF, `sram_we_n` low for 2 cycles then high for 1.
  - `sram_addr`=0x00025 with dq=0xDEAD, same strobe pattern.
  - `sram_not_ready` high for exactly 7 cycles.
- Read of idx 0x00012 against an SRAM model. Required: `oe_n` low for 4 cycles, `sram_not_ready` high for 5 cycles, then `rd_data`=0xDEADBEEF in DONE.
- Simultaneous `rd_en`=`wr_en`=1. Required: a write transaction is performed and `rd_data` is unchanged.
- Reset asserted in the 3rd READ cycle. Required: IDLE next cycle, `oe_n`=1, `rd_data`=0. A fresh read then completes normally.
- Variant `DATA_W`=16, `WAIT`=0. Required:
  - Read stalls 2 cycles.
  - Write stalls 3 cycles with `we_n` low for 1 cycle.
  - `sram_addr` equals `word_idx`.
